// File: rtl/vc_arbiter_pkg.sv
// Shared definitions for the VC arbiter and the switch control FSM.
package vc_arbiter_pkg;

  localparam int unsigned DATA_W_DEFAULT = 6;

  // Burst counter width; wide enough for any practical weight.
  localparam int unsigned CntW = 8;

  // Priority state encoding, shared with the switch FSM.
  localparam logic StPrio0 = 1'b0;
  localparam logic StPrio1 = 1'b1;

  // A VC may be served only if it has a word and that word's destination is not almost full.
  function automatic logic vc_eligible(logic empty, logic dest, logic d0_af, logic d1_af);
    return !empty && !(dest ? d1_af : d0_af);
  endfunction

endpackage

// File: rtl/wrr_grant.sv
// Weighted round-robin grant decision between two VCs; purely combinational.
module wrr_grant
  import vc_arbiter_pkg::*;
#(
  parameter int unsigned WEIGHT0 = 3,
  parameter int unsigned WEIGHT1 = 1
) (
  input  logic            eligible0_i,
  input  logic            eligible1_i,
  input  logic            state_i,
  input  logic [CntW-1:0] cnt_i,
  output logic            grant0_o,
  output logic            grant1_o,
  output logic            state_o,
  output logic [CntW-1:0] cnt_o
);

  localparam logic [CntW-1:0] LastCnt0 = CntW'(WEIGHT0 - 1);
  localparam logic [CntW-1:0] LastCnt1 = CntW'(WEIGHT1 - 1);

  // Favoured VC wins if eligible; otherwise the other VC is served without consuming the burst.
  always_comb begin
    grant0_o = 1'b0;
    grant1_o = 1'b0;
    state_o  = state_i;
    cnt_o    = cnt_i;
    if (state_i == StPrio0) begin
      if (eligible0_i) begin
        grant0_o = 1'b1;
        if (cnt_i == LastCnt0) begin
          state_o = StPrio1;
          cnt_o   = '0;
        end else begin
          cnt_o = cnt_i + CntW'(1);
        end
      end else if (eligible1_i) begin
        grant1_o = 1'b1;
        cnt_o    = '0;
      end
    end else begin
      if (eligible1_i) begin
        grant1_o = 1'b1;
        if (cnt_i == LastCnt1) begin
          state_o = StPrio0;
          cnt_o   = '0;
        end else begin
          cnt_o = cnt_i + CntW'(1);
        end
      end else if (eligible0_i) begin
        grant0_o = 1'b1;
        cnt_o    = '0;
      end
    end
  end

endmodule

// File: rtl/vc_arbiter.sv
// Two-VC weighted arbiter: pops the granted VC combinationally and pushes the word one cycle later.
module vc_arbiter
  import vc_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEFAULT,
  parameter int unsigned WEIGHT0 = 3,
  parameter int unsigned WEIGHT1 = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              active,
  input  logic              vc0_empty,
  input  logic              vc1_empty,
  input  logic [DATA_W-1:0] vc0_data,
  input  logic [DATA_W-1:0] vc1_data,
  input  logic              d0_almost_full,
  input  logic              d1_almost_full,
  output logic              vc0_pop,
  output logic              vc1_pop,
  output logic              d0_push,
  output logic              d1_push,
  output logic [DATA_W-1:0] data_out,
  output logic [7:0]        d0_count,
  output logic [7:0]        d1_count,
  output logic              idle
);

  logic            state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            d0_push_q, d1_push_q;
  logic [DATA_W-1:0] data_q;
  logic [7:0]      d0_count_q, d1_count_q;

  logic eligible0, eligible1;
  logic raw_grant0, raw_grant1;
  logic grant0, grant1;
  logic [DATA_W-1:0] grant_word;

  assign eligible0 = vc_eligible(vc0_empty, vc0_data[DATA_W-1], d0_almost_full, d1_almost_full);
  assign eligible1 = vc_eligible(vc1_empty, vc1_data[DATA_W-1], d0_almost_full, d1_almost_full);

  wrr_grant #(
    .WEIGHT0 (WEIGHT0),
    .WEIGHT1 (WEIGHT1)
  ) u_wrr_grant (
    .eligible0_i (eligible0),
    .eligible1_i (eligible1),
    .state_i     (state_q),
    .cnt_i       (cnt_q),
    .grant0_o    (raw_grant0),
    .grant1_o    (raw_grant1),
    .state_o     (state_d),
    .cnt_o       (cnt_d)
  );

  // Grants only count while enabled and out of reset; they drive the pops directly.
  always_comb begin
    grant0     = raw_grant0 && active && !reset;
    grant1     = raw_grant1 && active && !reset;
    grant_word = grant1 ? vc1_data : vc0_data;
  end

  // Arbitration state, registered push/data and per-destination counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StPrio0;
      cnt_q      <= '0;
      d0_push_q  <= 1'b0;
      d1_push_q  <= 1'b0;
      data_q     <= '0;
      d0_count_q <= '0;
      d1_count_q <= '0;
    end else begin
      d0_count_q <= d0_count_q + {7'd0, d0_push_q};
      d1_count_q <= d1_count_q + {7'd0, d1_push_q};
      if (grant0 || grant1) begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        data_q    <= grant_word;
        d0_push_q <= !grant_word[DATA_W-1];
        d1_push_q <= grant_word[DATA_W-1];
      end else begin
        d0_push_q <= 1'b0;
        d1_push_q <= 1'b0;
      end
    end
  end

  assign vc0_pop  = grant0;
  assign vc1_pop  = grant1;
  assign d0_push  = d0_push_q;
  assign d1_push  = d1_push_q;
  assign data_out = data_q;
  assign d0_count = d0_count_q;
  assign d1_count = d1_count_q;
  assign idle     = vc0_empty && vc1_empty && !d0_push_q && !d1_push_q;

endmodule

// File: tb/tb_vc_arbiter.sv
// Bench for vc_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_vc_arbiter;

  localparam int DW = 6;
  localparam int W0 = 3;
  localparam int W1 = 1;

  logic          clk = 1'b0;
  logic          reset, active, vc0_empty, vc1_empty, d0_af, d1_af;
  logic [DW-1:0] vc0_data, vc1_data, data_out;
  logic          vc0_pop, vc1_pop, d0_push, d1_push, idle;
  logic [7:0]    d0_count, d1_count;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: which VC is favoured, grants used in the current burst, expected registered outputs.
  int            m_prio, m_used;
  logic          m_p0, m_p1;
  logic [DW-1:0] m_data;
  int            m_c0, m_c1;

  vc_arbiter #(
    .DATA_W  (DW),
    .WEIGHT0 (W0),
    .WEIGHT1 (W1)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .active         (active),
    .vc0_empty      (vc0_empty),
    .vc1_empty      (vc1_empty),
    .vc0_data       (vc0_data),
    .vc1_data       (vc1_data),
    .d0_almost_full (d0_af),
    .d1_almost_full (d1_af),
    .vc0_pop        (vc0_pop),
    .vc1_pop        (vc1_pop),
    .d0_push        (d0_push),
    .d1_push        (d1_push),
    .data_out       (data_out),
    .d0_count       (d0_count),
    .d1_count       (d1_count),
    .idle           (idle)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit elig(input logic empty, input logic [DW-1:0] w);
    return !empty && !(w[DW-1] ? d1_af : d0_af);
  endfunction

  // 0: no grant, 1: VC0, 2: VC1.
  function automatic int pick();
    bit e[2];
    if (reset || !active) return 0;
    e[0] = elig(vc0_empty, vc0_data);
    e[1] = elig(vc1_empty, vc1_data);
    if (e[m_prio]) return m_prio + 1;
    if (e[1 - m_prio]) return 2 - m_prio;
    return 0;
  endfunction

  task automatic drive(input bit r, input bit a, input bit e0, input bit e1,
                       input bit af0, input bit af1,
                       input logic [DW-1:0] w0, input logic [DW-1:0] w1);
    reset = r; active = a; vc0_empty = e0; vc1_empty = e1;
    d0_af = af0; d1_af = af1; vc0_data = w0; vc1_data = w1;
  endtask

  // One clock: check pops before the edge, advance the model, check registered outputs after.
  task automatic step();
    int            g;
    logic [DW-1:0] w;
    #1;
    g = pick();
    check("vc0_pop", {31'd0, vc0_pop}, {31'd0, g == 1});
    check("vc1_pop", {31'd0, vc1_pop}, {31'd0, g == 2});
    @(posedge clk);
    if (reset) begin
      m_prio = 0; m_used = 0; m_p0 = 0; m_p1 = 0; m_data = '0; m_c0 = 0; m_c1 = 0;
    end else begin
      m_c0 = (m_c0 + int'(m_p0)) % 256;
      m_c1 = (m_c1 + int'(m_p1)) % 256;
      if (g == 0) begin
        m_p0 = 0; m_p1 = 0;
      end else begin
        w      = (g == 1) ? vc0_data : vc1_data;
        m_data = w;
        m_p1   = w[DW-1];
        m_p0   = !w[DW-1];
        if (g - 1 == m_prio) begin
          m_used++;
          if (m_used == ((m_prio == 1) ? W1 : W0)) begin
            m_prio = 1 - m_prio;
            m_used = 0;
          end
        end else begin
          m_used = 0;
        end
      end
    end
    #1;
    check("d0_push", {31'd0, d0_push}, {31'd0, m_p0});
    check("d1_push", {31'd0, d1_push}, {31'd0, m_p1});
    check("data_out", {26'd0, data_out}, {26'd0, m_data});
    check("d0_count", {24'd0, d0_count}, m_c0);
    check("d1_count", {24'd0, d1_count}, m_c1);
    check("idle", {31'd0, idle}, {31'd0, vc0_empty && vc1_empty && !m_p0 && !m_p1});
  endtask

  initial begin
    m_prio = 0; m_used = 0; m_p0 = 0; m_p1 = 0; m_data = '0; m_c0 = 0; m_c1 = 0;

    // Reset for two cycles, then idle with both VCs empty.
    drive(1, 1, 1, 1, 0, 0, '0, '0);
    step(); step();
    drive(0, 1, 1, 1, 0, 0, '0, '0);
    step(); step();
    check("idle_after_reset", {31'd0, idle}, 32'd1);

    // Both VCs busy towards D0: weighted 3:1 pattern, 8 grants.
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 0, 0, 0, 0, DW'($urandom_range(0, 31)), DW'($urandom_range(0, 31)));
      step();
    end
    drive(0, 0, 0, 0, 0, 0, '0, '0);
    step();
    check("d0_count_8", {24'd0, d0_count}, 32'd8);

    // VC0 blocked by D1 almost full; VC1 served towards D0, then VC0 once unblocked.
    drive(0, 1, 0, 0, 0, 1, 6'b100101, 6'b000011);
    step();
    check("blocked_data", {26'd0, data_out}, 32'h03);
    check("blocked_d0_push", {31'd0, d0_push}, 32'd1);
    drive(0, 1, 0, 1, 0, 0, 6'b100101, 6'b000011);
    step();
    check("unblocked_d1_push", {31'd0, d1_push}, 32'd1);

    // active dropped mid-burst after one VC0 grant, then resumed.
    drive(1, 1, 1, 1, 0, 0, '0, '0);
    step();
    drive(0, 1, 0, 0, 0, 0, 6'h01, 6'h02);
    step();
    drive(0, 0, 0, 0, 0, 0, 6'h01, 6'h02);
    step(); step(); step();
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 0, 0, 0, DW'($urandom_range(0, 31)), DW'($urandom_range(0, 31)));
      step();
    end

    // Reset right after a VC0 pop discards the in-flight push.
    drive(0, 1, 0, 1, 0, 0, 6'h05, 6'h00);
    step();
    drive(1, 1, 0, 1, 0, 0, 6'h05, 6'h00);
    step();
    check("rst_d0_push", {31'd0, d0_push}, 32'd0);
    check("rst_d0_count", {24'd0, d0_count}, 32'd0);
    drive(0, 1, 0, 1, 0, 0, 6'h05, 6'h00);
    step();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) != 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
            DW'($urandom), DW'($urandom));
      step();
    end

    // d0_count wrap: 255 pushes, then one more.
    drive(1, 1, 1, 1, 0, 0, '0, '0);
    step();
    for (int i = 0; i < 255; i++) begin
      drive(0, 1, 0, 1, 0, 0, DW'($urandom_range(0, 31)), '0);
      step();
    end
    drive(0, 0, 0, 1, 0, 0, '0, '0);
    step();
    check("d0_count_255", {24'd0, d0_count}, 32'd255);
    drive(0, 1, 0, 1, 0, 0, 6'h11, '0);
    step();
    drive(0, 0, 0, 1, 0, 0, '0, '0);
    step();
    check("d0_count_wrap", {24'd0, d0_count}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
